// File: rtl/mac_pkg.sv
// Shared types and Q8.8 constants for the MAC sequencer and its address generator.
package mac_pkg;

    localparam int MAC_DATA_W = 16;
    localparam int MAC_FRAC_W = 8;
    localparam logic [MAC_DATA_W-1:0] MAC_ONE = 16'h0100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FETCH  = 3'd2,
        ST_DRAIN1 = 3'd3,
        ST_DRAIN2 = 3'd4,
        ST_DONE   = 3'd5
    } mac_seq_state_t;

endpackage

// File: rtl/mac_addr_gen.sv
// Tap counter plus the pixel/weight base+k address adders; addresses wrap mod 2^ADDR_W.
module mac_addr_gen
    import mac_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W:0]   len,
    input  logic [ADDR_W-1:0] pix_base,
    input  logic [ADDR_W-1:0] wt_base,
    output logic              last,
    output logic              len_zero,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [ADDR_W-1:0] wt_addr
);

    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] pix_base_q;
    logic [ADDR_W-1:0] wt_base_q;
    logic [ADDR_W-1:0] k;

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q      <= '0;
            pix_base_q <= '0;
            wt_base_q  <= '0;
            k          <= '0;
        end else if (load) begin
            len_q      <= len;
            pix_base_q <= pix_base;
            wt_base_q  <= wt_base;
            k          <= '0;
        end else if (step) begin
            k <= k + 1'b1;
        end
    end

    // k only needs ADDR_W bits: the largest tap index is 2^ADDR_W-1
    assign last     = ({1'b0, k} == (len_q - 1'b1));
    assign len_zero = (len_q == '0);
    assign pix_addr = pix_base_q + k;
    assign wt_addr  = wt_base_q + k;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the Q8.8 MAC: clear, stream len operand pairs from RAM, drain, hand back the dot product.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start; bases and len latched on accept
// CLEAR     | one cycle, MAC held in reset
// FETCH     | len cycles of RAM reads at base+k
// DRAIN1/2  | let the last read and the MAC register settle
// DONE      | out_valid high until out_ready
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = MAC_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [ADDR_W-1:0] pix_base,
    input  logic [ADDR_W-1:0] wt_base,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [ADDR_W-1:0] wt_addr,
    input  logic [DATA_W-1:0] pix_rdata,
    input  logic [DATA_W-1:0] wt_rdata,
    output logic              mac_rst,
    output logic [DATA_W-1:0] mac_pixel,
    output logic [DATA_W-1:0] mac_weight,
    input  logic [DATA_W-1:0] mac_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    mac_seq_state_t state;
    logic           dvalid;
    logic           last;
    logic           len_zero;
    logic           load;
    logic           step;

    assign load = (state == ST_IDLE) && start;
    assign step = (state == ST_FETCH);

    mac_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .len      (len),
        .pix_base (pix_base),
        .wt_base  (wt_base),
        .last     (last),
        .len_zero (len_zero),
        .pix_addr (pix_addr),
        .wt_addr  (wt_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            dvalid    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            dvalid <= rd_en;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_CLEAR;
                        busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (len_zero) begin
                        state <= ST_DRAIN1;
                    end else begin
                        state <= ST_FETCH;
                        rd_en <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (last) begin
                        state <= ST_DRAIN1;
                        rd_en <= 1'b0;
                    end
                end
                ST_DRAIN1: state <= ST_DRAIN2;
                ST_DRAIN2: begin
                    state     <= ST_DONE;
                    out_data  <= mac_result;
                    out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // zero operands outside data cycles keep the free-running MAC accumulator frozen
    assign mac_pixel  = dvalid ? pix_rdata : '0;
    assign mac_weight = dvalid ? wt_rdata  : '0;
    assign mac_rst    = reset || (state == ST_CLEAR);

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the Q8.8 multiply-accumulate unit: on a start command it clears the MAC, streams `len` pixel/weight pairs from two synchronous-read memories into it, drains the pipeline, and returns the 16-bit dot product over a valid/ready handshake. It sits between the layer controller (command side) and one MAC instance plus its pixel and weight RAMs. Outside active data cycles it drives zero operands, so the MAC's free-running accumulation stays stable.

## Interface
Parameters:
- `ADDR_W`, default 10: memory address width. Maximum `len` is 2^ADDR_W.
- `DATA_W`, default 16: operand and result width, Q8.8.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high; clock clk.
- `start`  in  1: command strobe. Accepted only in IDLE.
- `len`  in  ADDR_W+1: number of taps. Sampled with `start`.
- `pix_base`  in  ADDR_W: pixel start address. Sampled with `start`.
- `wt_base`  in  ADDR_W: weight start address. Sampled with `start`.
- `busy`  out  1: high in any state except IDLE.
- `rd_en`  out  1: read strobe to both RAMs.
- `pix_addr`  out  ADDR_W: pixel RAM address.
- `wt_addr`  out  ADDR_W: weight RAM address.
- `pix_rdata`  in  DATA_W: pixel RAM data, valid 1 cycle after `rd_en`.
- `wt_rdata`  in  DATA_W: weight RAM data, valid 1 cycle after `rd_en`.
- `mac_rst`  out  1: MAC reset.
- `mac_pixel`  out  DATA_W: MAC pixel operand.
- `mac_weight`  out  DATA_W: MAC weight operand.
- `mac_result`  in  DATA_W: MAC accumulator output (registered in the MAC).
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer accepts the result.
- `out_data`  out  DATA_W: captured dot product.

## Operation
- State machine: IDLE → CLEAR → FETCH → DRAIN1 → DRAIN2 → DONE → IDLE.
- IDLE: on `start`, latch `len`, `pix_base` and `wt_base`, then go to CLEAR.
- CLEAR (1 cycle): `mac_rst`=1. Tap counter k=0. Go to FETCH, or to DRAIN1 if `len`=0.
- FETCH (`len` cycles): `rd_en`=1, `pix_addr`=pix_base+k mod 2^ADDR_W, `wt_addr`=wt_base+k mod 2^ADDR_W. k increments each cycle. Go to DRAIN1 after k=len-1.
- `dvalid` is `rd_en` delayed by one register stage.
  - `mac_pixel`/`mac_weight` = RAM data when `dvalid`=1, else 0.
  - These outputs are combinational from the registered `dvalid`.
- DRAIN1 and DRAIN2 are one cycle each. At the end of DRAIN2, `out_data` <= `mac_result`.
- DONE: `out_valid`=1, and `out_data` holds its value. On `out_valid & out_ready`, go to IDLE.
- Arithmetic is the MAC's own: sum of product[23:8], truncated mod 2^16. There is no saturation. The controller does not alter the result.
- `start` in any state other than IDLE is ignored, including the handshake cycle.
- `mac_rst` = `reset` OR (state==CLEAR).

## Timing
- Reset values:
  - state IDLE; `busy`=0, `rd_en`=0, `pix_addr`=0, `wt_addr`=0.
  - `mac_rst`=1 (during reset), `mac_pixel`=0, `mac_weight`=0.
  - `out_valid`=0, `out_data`=0; `dvalid`=0.
- Reference cycle: `start` accepted in cycle s.
  - CLEAR is cycle s+1.
  - FETCH covers s+2 .. s+len+1.
  - Tap k data reaches the MAC in cycle s+k+3.
  - `out_valid` rises in cycle s+len+4.
- `len`=0: `out_valid` rises in s+4 with `out_data`=0.
- `busy` rises in s+1 and falls the cycle after the handshake.
- Back-to-back: the earliest next `start` is accepted the cycle after the handshake.
- `out_ready` low holds DONE indefinitely. The MAC sees zero operands, so `mac_result` and `out_data` are stable.
- Reset mid-operation: next cycle returns to IDLE. Any pending result is dropped and the MAC is cleared.
- Address wrap: base+k past 2^ADDR_W-1 wraps to 0 with no error flag.

## Structure
- Package `mac_pkg`:
  - state enum `mac_seq_state_t`;
  - `MAC_DATA_W`=16 and `MAC_FRAC_W`=8;
  - Q8.8 constant `MAC_ONE`=16'h0100.
- One natural sub-module: `mac_addr_gen`. It holds the tap counter and the two base+k address adders, and takes load/step/last signals.
- The MAC itself stays external, instantiated by the parent beside this block.

## Test plan
- Basic dot product:
  - `len`=3, pixels 0x0100/0x0200/0x0080, weights 0x0100/0x0180/0x0400.
  - Expect `out_data`=0x0600 with `out_valid` at s+7.
- Overflow wrap: `len`=2, pixels 0x7F00/0x7F00, weights 0x0200/0x0200. Expect `out_data`=0xFC00.
- Empty command: `len`=0. Expect `rd_en` never high, `out_valid` at s+4, `out_data`=0.
- Address wrap and backpressure:
  - `pix_base`=0x3FE, `len`=4: expect `pix_addr` sequence 0x3FE, 0x3FF, 0x000, 0x001.
  - Hold `out_ready`=0 for 10 cycles: `out_data` stays constant.
  - `start` pulses during `busy` are ignored.
- Reset mid-FETCH:
  - Assert `reset` at k=2 of a `len`=8 command. Expect IDLE, `rd_en`=0 and `mac_rst`=1.
  - A new `len`=1 command (pixel 0x0300, weight 0x0100) then returns 0x0300, with no residue from the aborted command.
